// File: rtl/ks_data_path_p_if.sv
// Bundle of control strobes, status flags and RAM bus between the K&S control
// unit / RAM (master side) and the K&S data path (slave side).
interface ks_data_path_p_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              branch;
    logic              pc_enable;
    logic              ir_enable;
    logic              addr_sel;
    logic              c_sel;
    logic [2:0]        operation;
    logic              write_reg_enable;
    logic              flags_reg_enable;
    logic [3:0]        decoded_instruction;
    logic              zero_op;
    logic              neg_op;
    logic              unsigned_overflow;
    logic              signed_overflow;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] data_in;
    logic [31:0]       instr_count;

    modport master (
        output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out, instr_count
    );

    modport slave (
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
               write_reg_enable, flags_reg_enable, data_in,
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out, instr_count
    );
endinterface

// File: rtl/ks_data_path_p.sv
// Parametrised K&S data path: PC, IR, register file, eight-op ALU, flags and
// retired-instruction counter; every enable and select comes from the control unit.
module ks_data_path_p #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int NREG    = 4,
    parameter bit ZERO_R0 = 1'b0
) (
    input logic          clk,
    input logic          rst_n,
    ks_data_path_p_if.slave bus
);
    localparam int REG_W = $clog2(NREG);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_e;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [NREG];
    logic [3:0]        flags;
    logic [31:0]       instr_count;

    logic [REG_W-1:0]  rc_idx;
    logic [REG_W-1:0]  ra_idx;
    logic [REG_W-1:0]  rb_idx;
    logic [ADDR_W-1:0] ir_addr;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_c;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   alu_wide;
    logic              alu_uov;
    logic              alu_sov;
    logic [DATA_W-1:0] wb_data;
    logic              rc_writable;
    logic              unused_bits;

    assign rc_idx  = ir[8 +: REG_W];
    assign ra_idx  = ir[4 +: REG_W];
    assign rb_idx  = ir[0 +: REG_W];
    assign ir_addr = ir[ADDR_W-1:0];
    assign unused_bits = ^{ir, bus.data_in};

    // With ZERO_R0 the r0 read port is a constant zero, so stale contents never leak out.
    assign op_a = (ZERO_R0 && ra_idx == '0) ? '0 : rf[ra_idx];
    assign op_b = (ZERO_R0 && rb_idx == '0) ? '0 : rf[rb_idx];
    assign op_c = (ZERO_R0 && rc_idx == '0) ? '0 : rf[rc_idx];
    assign rc_writable = !(ZERO_R0 && rc_idx == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        alu_res  = '0;
        alu_wide = '0;
        alu_uov  = 1'b0;
        alu_sov  = 1'b0;
        case (alu_op_e'(bus.operation))
            OP_ADD: begin
                alu_wide = {1'b0, op_a} + {1'b0, op_b};
                alu_res  = alu_wide[MSB:0];
                alu_uov  = alu_wide[DATA_W];
                alu_sov  = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                // The extra top bit of the widened difference is the borrow.
                alu_wide = {1'b0, op_a} - {1'b0, op_b};
                alu_res  = alu_wide[MSB:0];
                alu_uov  = alu_wide[DATA_W];
                alu_sov  = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SHL: begin
                alu_res = {op_a[MSB-1:0], 1'b0};
                alu_uov = op_a[MSB];
            end
            OP_SHR: begin
                alu_res = {1'b0, op_a[MSB:1]};
                alu_uov = op_a[0];
            end
            OP_PASS: alu_res = op_a;
            default: alu_res = op_a;
        endcase
    end

    assign wb_data = bus.c_sel ? bus.data_in : alu_res;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            flags       <= '0;
            instr_count <= '0;
            // NOTE: the register file is reset because its contents are architecturally visible after reset.
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            // NOTE: non-blocking updates let PC, IR, registers and flags all sample the same old state.
            if (bus.pc_enable) pc <= bus.branch ? ir_addr : pc + ADDR_W'(1);
            if (bus.ir_enable) begin
                ir <= bus.data_in[15:0];
                if (instr_count != '1) instr_count <= instr_count + 32'd1;
            end
            if (bus.flags_reg_enable)
                flags <= {alu_res == '0, alu_res[MSB], alu_uov, alu_sov};
            if (bus.write_reg_enable && rc_writable) rf[rc_idx] <= wb_data;
        end
    end

    assign bus.decoded_instruction = ir[15:12];
    assign bus.zero_op             = flags[3];
    assign bus.neg_op              = flags[2];
    assign bus.unsigned_overflow   = flags[1];
    assign bus.signed_overflow     = flags[0];
    assign bus.ram_addr            = bus.addr_sel ? ir_addr : pc;
    assign bus.data_out            = op_c;
    assign bus.instr_count         = instr_count;
endmodule

// File: tb/tb_ks_data_path_p.sv
// Bench for ks_data_path_p: two instances (4 regs plain, 16 regs with hard-wired
// r0) driven identically and compared against an arithmetic reference model.
module tb_ks_data_path_p;
    localparam int NREG_OF [2] = '{4, 16};
    localparam bit ZR0_OF  [2] = '{1'b0, 1'b1};

    typedef struct packed {
        bit        branch;
        bit        pc_en;
        bit        ir_en;
        bit        addr_sel;
        bit        c_sel;
        bit [2:0]  op;
        bit        wre;
        bit        fre;
        bit [15:0] din;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]  dec;
        logic [3:0]  flags;
        logic [4:0]  addr;
        logic [15:0] dout;
        logic [31:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    int unsigned m_pc [2];
    int unsigned m_ir [2];
    int unsigned m_rf [2][16];
    logic [3:0]  m_flags [2];
    int unsigned m_cnt [2];

    always #5 clk = ~clk;

    ks_data_path_p_if #(.DATA_W(16), .ADDR_W(5)) bus0 ();
    ks_data_path_p_if #(.DATA_W(16), .ADDR_W(5)) bus1 ();

    ks_data_path_p #(.DATA_W(16), .ADDR_W(5), .NREG(4), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0));
    ks_data_path_p #(.DATA_W(16), .ADDR_W(5), .NREG(16), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    // ---------------- reference model ----------------
    function automatic int unsigned rd(int k, int unsigned field);
        int unsigned i = field % NREG_OF[k];
        if (ZR0_OF[k] && i == 0) return 0;
        return m_rf[k][i];
    endfunction

    function automatic void alu(input int unsigned op, input int unsigned a, input int unsigned b,
                                output int unsigned res, output logic [3:0] fl);
        bit u = 1'b0, s = 1'b0;
        case (op)
            0: begin res = (a + b) % 65536; u = (a + b) > 65535;
                     s = ((a >= 32768) == (b >= 32768)) && ((res >= 32768) != (a >= 32768)); end
            1: begin res = (a + 65536 - b) % 65536; u = a < b;
                     s = ((a >= 32768) != (b >= 32768)) && ((res >= 32768) != (a >= 32768)); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 65536; u = a >= 32768; end
            6: begin res = a / 2; u = (a % 2) == 1; end
            default: res = a;
        endcase
        fl = {res == 0, res >= 32768, u, s};
    endfunction

    function automatic void model_tick(int k, ctrl_t c, bit rst);
        int unsigned a, b, res, rc;
        logic [3:0] fl;
        if (rst) begin
            m_pc[k] = 0; m_ir[k] = 0; m_flags[k] = '0; m_cnt[k] = 0;
            for (int i = 0; i < 16; i++) m_rf[k][i] = 0;
            return;
        end
        rc = (m_ir[k] >> 8) % NREG_OF[k];
        a  = rd(k, (m_ir[k] >> 4) & 15);
        b  = rd(k, m_ir[k] & 15);
        alu(c.op, a, b, res, fl);
        if (c.fre) m_flags[k] = fl;
        if (c.wre && !(ZR0_OF[k] && rc == 0)) m_rf[k][rc] = c.c_sel ? c.din : res;
        if (c.pc_en) m_pc[k] = c.branch ? m_ir[k] % 32 : (m_pc[k] + 1) % 32;
        if (c.ir_en) begin
            m_ir[k] = c.din;
            if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 1;
        end
    endfunction

    function automatic obs_t model_obs(int k, bit addr_sel);
        obs_t o;
        o.dec   = 4'(m_ir[k] >> 12);
        o.flags = m_flags[k];
        o.addr  = 5'(addr_sel ? m_ir[k] % 32 : m_pc[k]);
        o.dout  = 16'(rd(k, (m_ir[k] >> 8) & 15));
        o.cnt   = m_cnt[k];
        return o;
    endfunction

    function automatic obs_t get_obs(int k);
        if (k == 0)
            return {bus0.decoded_instruction, bus0.zero_op, bus0.neg_op, bus0.unsigned_overflow,
                    bus0.signed_overflow, bus0.ram_addr, bus0.data_out, bus0.instr_count};
        return {bus1.decoded_instruction, bus1.zero_op, bus1.neg_op, bus1.unsigned_overflow,
                bus1.signed_overflow, bus1.ram_addr, bus1.data_out, bus1.instr_count};
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic ctrl_t idle();
        ctrl_t c = '0;
        return c;
    endfunction

    task automatic drive(input ctrl_t c);
        bus0.branch = c.branch;   bus1.branch = c.branch;
        bus0.pc_enable = c.pc_en; bus1.pc_enable = c.pc_en;
        bus0.ir_enable = c.ir_en; bus1.ir_enable = c.ir_en;
        bus0.addr_sel = c.addr_sel; bus1.addr_sel = c.addr_sel;
        bus0.c_sel = c.c_sel;     bus1.c_sel = c.c_sel;
        bus0.operation = c.op;    bus1.operation = c.op;
        bus0.write_reg_enable = c.wre; bus1.write_reg_enable = c.wre;
        bus0.flags_reg_enable = c.fre; bus1.flags_reg_enable = c.fre;
        bus0.data_in = c.din;     bus1.data_in = c.din;
    endtask

    task automatic step(input ctrl_t c, input bit rst);
        drive(c);
        rst_n = ~rst;
        for (int k = 0; k < 2; k++) model_tick(k, c, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input bit addr_sel);
        ctrl_t c = idle();
        c.addr_sel = addr_sel;
        drive(c);
        #1;
    endtask

    task automatic load_ir(input bit [15:0] instr);
        ctrl_t c = idle();
        c.ir_en = 1'b1;
        c.din   = instr;
        step(c, 1'b0);
    endtask

    task automatic write_reg(input bit [3:0] rc, input bit [15:0] val);
        ctrl_t c = idle();
        load_ir({4'h3, rc, 8'h00});
        c.c_sel = 1'b1;
        c.wre   = 1'b1;
        c.din   = val;
        step(c, 1'b0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctrl_t c = '1;
        obs_t o;
        c.addr_sel = 1'b0;
        c.din = 16'($urandom);
        step(c, 1'b1);
        peek(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o !== '0) begin
                miscompares++;
                $display("FAIL reset dut%0d got %h want all-zero", k, o);
            end
        end
    endtask

    task automatic test_fetch_wrap();
        ctrl_t c = idle();
        obs_t o;
        c.ir_en = 1'b1; c.pc_en = 1'b1; c.din = 16'h4123;
        for (int i = 1; i <= 32; i++) begin
            step(c, 1'b0);
            for (int k = 0; k < 2; k++) begin
                o = get_obs(k);
                if (i == 1) begin
                    vectors++;
                    if (o.dec !== 4'd4 || o.addr !== 5'd1) begin
                        miscompares++;
                        $display("FAIL fetch_first dut%0d got dec=%0d pc=%0d want dec=4 pc=1", k, o.dec, o.addr);
                    end
                end
                if (i == 31) begin
                    vectors++;
                    if (o.addr !== 5'd31) begin
                        miscompares++;
                        $display("FAIL fetch_pc31 dut%0d got %0d want 31", k, o.addr);
                    end
                end
                if (i == 32) begin
                    vectors++;
                    if (o.addr !== 5'd0 || o.cnt !== 32'd32) begin
                        miscompares++;
                        $display("FAIL fetch_wrap dut%0d got pc=%0d cnt=%0d want pc=0 cnt=32", k, o.addr, o.cnt);
                    end
                end
            end
        end
    endtask

    task automatic test_alu_flags();
        ctrl_t c = idle();
        obs_t o;
        write_reg(4'd1, 16'h7FFF);
        write_reg(4'd2, 16'h0001);
        load_ir(16'h4312);
        c.op = 3'd0; c.wre = 1'b1; c.fre = 1'b1;
        step(c, 1'b0);
        peek(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.dout !== 16'h8000 || o.flags !== 4'b0101) begin
                miscompares++;
                $display("FAIL alu_add dut%0d got r3=%h flags=%b want 8000 0101", k, o.dout, o.flags);
            end
        end
        write_reg(4'd1, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.flags !== 4'b0101) begin
                miscompares++;
                $display("FAIL flags_hold dut%0d got %b want 0101", k, o.flags);
            end
        end
        load_ir(16'h5312);
        c.op = 3'd1;
        step(c, 1'b0);
        peek(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.dout !== 16'hFFFF || o.flags !== 4'b0110) begin
                miscompares++;
                $display("FAIL alu_sub dut%0d got r3=%h flags=%b want ffff 0110", k, o.dout, o.flags);
            end
        end
    endtask

    task automatic test_load_store_branch();
        ctrl_t c = idle();
        obs_t o;
        load_ir(16'h1213);
        peek(1'b1);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.addr !== 5'h13 || o.dec !== 4'd1) begin
                miscompares++;
                $display("FAIL load_addr dut%0d got addr=%h dec=%0d want 13 1", k, o.addr, o.dec);
            end
        end
        c.c_sel = 1'b1; c.wre = 1'b1; c.din = 16'hBEEF;
        step(c, 1'b0);
        load_ir(16'h2213);
        peek(1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.dout !== 16'hBEEF) begin
                miscompares++;
                $display("FAIL store_data dut%0d got %h want beef", k, o.dout);
            end
        end
        load_ir(16'h8007);
        c = idle(); c.pc_en = 1'b1; c.branch = 1'b1;
        step(c, 1'b0);
        c.branch = 1'b0;
        step(c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.addr !== 5'd8) begin
                miscompares++;
                $display("FAIL branch_then_inc dut%0d got pc=%0d want 8", k, o.addr);
            end
        end
        c = idle(); c.pc_en = 1'b1; c.branch = 1'b1; c.ir_en = 1'b1; c.din = 16'h8015;
        step(c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.addr !== 5'd7 || o.dec !== 4'd8) begin
                miscompares++;
                $display("FAIL branch_old_ir dut%0d got pc=%0d dec=%0d want 7 8", k, o.addr, o.dec);
            end
        end
        c = idle(); c.pc_en = 1'b1; c.branch = 1'b1;
        step(c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.addr !== 5'h15) begin
                miscompares++;
                $display("FAIL branch_new_ir dut%0d got pc=%h want 15", k, o.addr);
            end
        end
    endtask

    task automatic test_zero_r0();
        obs_t o0, o1;
        write_reg(4'd0, 16'h5555);
        o0 = get_obs(0); o1 = get_obs(1);
        vectors++;
        if (o0.dout !== 16'h5555 || o1.dout !== 16'h0000) begin
            miscompares++;
            $display("FAIL zero_r0 got dut0=%h dut1=%h want 5555 0000", o0.dout, o1.dout);
        end
        write_reg(4'd15, 16'h1234);
        write_reg(4'd3, 16'hAAAA);
        load_ir(16'h3F00);
        o0 = get_obs(0); o1 = get_obs(1);
        vectors++;
        if (o0.dout !== 16'hAAAA || o1.dout !== 16'h1234) begin
            miscompares++;
            $display("FAIL reg15_indep got dut0=%h dut1=%h want aaaa 1234", o0.dout, o1.dout);
        end
        load_ir(16'h3000);
        o0 = get_obs(0); o1 = get_obs(1);
        vectors++;
        if (o0.dout !== 16'h5555 || o1.dout !== 16'h0000) begin
            miscompares++;
            $display("FAIL r0_readback got dut0=%h dut1=%h want 5555 0000", o0.dout, o1.dout);
        end
    endtask

    task automatic test_hazard();
        ctrl_t c = idle();
        obs_t o;
        write_reg(4'd1, 16'h0005);
        write_reg(4'd2, 16'h0003);
        load_ir(16'h4112);
        c.op = 3'd0; c.fre = 1'b1; c.wre = 1'b1; c.c_sel = 1'b1; c.din = 16'hFFFD;
        step(c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.flags !== 4'b0000 || o.dout !== 16'hFFFD) begin
                miscompares++;
                $display("FAIL hazard_old dut%0d got flags=%b r1=%h want 0000 fffd", k, o.flags, o.dout);
            end
        end
        c.c_sel = 1'b0;
        step(c, 1'b0);
        for (int k = 0; k < 2; k++) begin
            o = get_obs(k);
            vectors++;
            if (o.flags !== 4'b1010 || o.dout !== 16'h0000) begin
                miscompares++;
                $display("FAIL hazard_new dut%0d got flags=%b r1=%h want 1010 0000", k, o.flags, o.dout);
            end
        end
    endtask

    task automatic test_random();
        ctrl_t c;
        obs_t o, e;
        for (int i = 0; i < 600; i++) begin
            c.branch   = 1'($urandom);
            c.pc_en    = 1'($urandom);
            c.ir_en    = ($urandom_range(0, 3) == 0);
            c.addr_sel = 1'($urandom);
            c.c_sel    = ($urandom_range(0, 3) == 0);
            c.op       = 3'($urandom);
            c.wre      = 1'($urandom);
            c.fre      = 1'($urandom);
            c.din      = 16'($urandom);
            step(c, $urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                o = get_obs(k);
                e = model_obs(k, c.addr_sel);
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL random dut%0d iter %0d got %h want %h", k, i, o, e);
                end
            end
        end
    endtask

    initial begin
        drive(idle());
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_wrap();
        test_alu_flags();
        test_load_store_branch();
        test_zero_r0();
        test_hazard();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
